// File: rtl/mem_ctrl_pkg.sv
// Shared types for the memory copy scheduler: controller states, default
// memory geometry and the owner tag carried alongside each 16-bit read.
package mem_ctrl_pkg;

  localparam int AW_DEF = 16;
  localparam int DW_DEF = 16;

  typedef enum logic [2:0] {
    IDLE,
    RUN,
    WAIT,
    WRITE,
    DONE
  } state_t;

  typedef enum logic {
    OWN_HOST,
    OWN_COPY
  } owner_t;

endpackage

// File: rtl/rd_tag_pipe.sv
// Read-tag pipeline: follows every 16-bit read for RD_LAT cycles so the
// returning word can be steered to the host or to the copy engine.
module rd_tag_pipe
  import mem_ctrl_pkg::*;
#(
  parameter int DW     = DW_DEF,
  parameter int RD_LAT = 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          issue,
  input  logic          issue_copy,
  input  logic [DW-1:0] rdata,
  output logic          host_rvalid,
  output logic [DW-1:0] host_rdata,
  output logic          copy_vld,
  output logic [DW-1:0] copy_rdata
);

  logic [RD_LAT-1:0] vld_p;
  owner_t            own_p [RD_LAT];

  // Shift the {valid, owner} tag one stage per cycle; reset drops in-flight reads.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      vld_p <= '0;
      for (int i = 0; i < RD_LAT; i++) begin
        own_p[i] <= OWN_HOST;
      end
    end else begin
      vld_p[0] <= issue;
      own_p[0] <= issue_copy ? OWN_COPY : OWN_HOST;
      for (int i = 1; i < RD_LAT; i++) begin
        vld_p[i] <= vld_p[i-1];
        own_p[i] <= own_p[i-1];
      end
    end
  end

  // The tail tag lines up with the memory return word; route it to its owner.
  always_comb begin
    host_rvalid = vld_p[RD_LAT-1] && (own_p[RD_LAT-1] == OWN_HOST);
    copy_vld    = vld_p[RD_LAT-1] && (own_p[RD_LAT-1] == OWN_COPY);
    host_rdata  = host_rvalid ? rdata : '0;
    copy_rdata  = copy_vld ? rdata : '0;
  end

endmodule

// File: rtl/mem_copy_sched.sv
// Copy scheduler: moves words from the 16-bit memory into the 8-bit memory
// (high byte = 8-bit address, low byte = data) while sharing the 16-bit
// port with a host requester, one access per cycle.
module mem_copy_sched
  import mem_ctrl_pkg::*;
#(
  parameter int AW     = AW_DEF,
  parameter int DW     = DW_DEF,
  parameter int RD_LAT = 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic            abort,
  input  logic [AW-1:0]   base_addr,
  input  logic [AW-1:0]   word_count,
  output logic            busy,
  output logic            done,
  output logic            aborted,
  output logic [AW-1:0]   copied,
  input  logic            host_req,
  input  logic            host_we,
  input  logic [AW-1:0]   host_addr,
  input  logic [DW-1:0]   host_wdata,
  output logic            host_gnt,
  output logic            host_rvalid,
  output logic [DW-1:0]   host_rdata,
  output logic [AW-1:0]   m16_addr,
  output logic            m16_we,
  output logic [DW-1:0]   m16_wdata,
  input  logic [DW-1:0]   m16_rdata,
  output logic [DW/2-1:0] m8_addr,
  output logic [DW/2-1:0] m8_wdata,
  output logic            m8_we
);

  localparam int            HW  = DW / 2;
  localparam logic [AW-1:0] ONE = AW'(1);

  state_t        state, state_nx;
  logic [AW-1:0] cur_addr;
  logic [AW-1:0] remaining;
  logic [DW-1:0] copy_word;
  logic          copy_gnt;
  logic          rr_host;     // host wins the next contested RUN slot
  logic          abort_hit;
  logic          accept;
  logic          rd_issue;
  logic          copy_vld;
  logic [DW-1:0] copy_rdata;

  assign accept   = (state == IDLE) && start;
  assign rd_issue = (host_gnt && !host_we) || copy_gnt;

  // Control state: FSM, progress counter, exit cause and round-robin pointer.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      copied    <= '0;
      abort_hit <= 1'b0;
      rr_host   <= 1'b1;
    end else begin
      state <= state_nx;
      if (accept) begin
        copied    <= '0;
        abort_hit <= 1'b0;
      end
      if (state == WRITE) begin
        copied    <= copied + ONE;
        abort_hit <= abort && (remaining != ONE);
      end
      if (state == RUN) begin
        rr_host <= copy_gnt;
      end
    end
  end

  // Copy datapath: source pointer, words left and the captured source word.
  always_ff @(posedge clk) begin
    if (accept) begin
      cur_addr  <= base_addr;
      remaining <= word_count;
    end else if (state == WRITE) begin
      cur_addr  <= cur_addr + ONE;
      remaining <= remaining - ONE;
    end
    if (copy_vld) begin
      copy_word <= copy_rdata;
    end
  end

  // Next-state logic: one read slot, RD_LAT wait, one 8-bit write per word.
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (start) state_nx = (word_count == '0) ? DONE : RUN;
      RUN:     if (copy_gnt) state_nx = WAIT;
      WAIT:    if (copy_vld) state_nx = WRITE;
      WRITE:   state_nx = ((remaining == ONE) || abort) ? DONE : RUN;
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Port arbitration: host always wins outside RUN; RUN alternates on contention.
  always_comb begin
    host_gnt = 1'b0;
    copy_gnt = 1'b0;
    if (rst) begin
      case (state)
        IDLE, WAIT, WRITE: host_gnt = host_req;
        RUN: begin
          if (host_req && rr_host) host_gnt = 1'b1;
          else                     copy_gnt = 1'b1;
        end
        default: ;
      endcase
    end
  end

  // 16-bit port mux: the granted requester drives the memory this cycle.
  always_comb begin
    m16_addr  = '0;
    m16_we    = 1'b0;
    m16_wdata = '0;
    if (host_gnt) begin
      m16_addr  = host_addr;
      m16_we    = host_we;
      m16_wdata = host_wdata;
    end else if (copy_gnt) begin
      m16_addr = cur_addr;
    end
  end

  // Status and 8-bit write outputs decoded from the current state.
  always_comb begin
    busy     = (state == RUN) || (state == WAIT) || (state == WRITE);
    done     = (state == DONE);
    aborted  = (state == DONE) && abort_hit;
    m8_we    = (state == WRITE);
    m8_addr  = m8_we ? copy_word[DW-1:HW] : '0;
    m8_wdata = m8_we ? copy_word[HW-1:0] : '0;
  end

  rd_tag_pipe #(
    .DW     (DW),
    .RD_LAT (RD_LAT)
  ) u_rd_tag_pipe (
    .clk         (clk),
    .rst         (rst),
    .issue       (rd_issue),
    .issue_copy  (copy_gnt),
    .rdata       (m16_rdata),
    .host_rvalid (host_rvalid),
    .host_rdata  (host_rdata),
    .copy_vld    (copy_vld),
    .copy_rdata  (copy_rdata)
  );

endmodule

// File: tb/tb_mem_copy_sched.sv
// Bench for mem_copy_sched: 16-bit memory model with RD_LAT read latency,
// a host traffic generator and a word-level reference of the copy rules.
module tb_mem_copy_sched;

  localparam int AW     = 16;
  localparam int DW     = 16;
  localparam int RD_LAT = 1;

  logic          clk, rst, start, abort;
  logic [AW-1:0] base_addr, word_count, copied;
  logic          busy, done, aborted;
  logic          host_req, host_we, host_gnt, host_rvalid;
  logic [AW-1:0] host_addr, m16_addr;
  logic [DW-1:0] host_wdata, host_rdata, m16_wdata, m16_rdata;
  logic          m16_we, m8_we;
  logic [7:0]    m8_addr, m8_wdata;

  mem_copy_sched #(.AW(AW), .DW(DW), .RD_LAT(RD_LAT)) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort),
    .base_addr(base_addr), .word_count(word_count),
    .busy(busy), .done(done), .aborted(aborted), .copied(copied),
    .host_req(host_req), .host_we(host_we), .host_addr(host_addr),
    .host_wdata(host_wdata), .host_gnt(host_gnt), .host_rvalid(host_rvalid),
    .host_rdata(host_rdata), .m16_addr(m16_addr), .m16_we(m16_we),
    .m16_wdata(m16_wdata), .m16_rdata(m16_rdata), .m8_addr(m8_addr),
    .m8_wdata(m8_wdata), .m8_we(m8_we)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc;
  always @(posedge clk) cyc <= cyc + 1;

  // 16-bit memory model plus a reference image updated from host writes
  logic [DW-1:0] mem16 [0:65535];
  logic [DW-1:0] ref16 [0:65535];
  logic [DW-1:0] rd_pipe [RD_LAT];
  logic          preload, bd_we;
  logic [AW-1:0] bd_addr;
  logic [DW-1:0] bd_data, pre_v;

  always @(posedge clk) begin
    if (preload) begin
      for (int i = 0; i < 65536; i++) begin
        pre_v = 16'($urandom);
        mem16[i] <= pre_v;
        ref16[i] <= pre_v;
      end
    end else if (bd_we) begin
      mem16[bd_addr] <= bd_data;
      ref16[bd_addr] <= bd_data;
    end else begin
      if (m16_we) mem16[m16_addr] <= m16_wdata;
      if (host_gnt && host_we) ref16[host_addr] <= host_wdata;
    end
    rd_pipe[0] <= mem16[m16_addr];
    for (int i = 1; i < RD_LAT; i++) rd_pipe[i] <= rd_pipe[i-1];
  end
  assign m16_rdata = rd_pipe[RD_LAT-1];

  // Observation: 8-bit writes, done pulses, grants and host read returns
  logic [7:0]    wr_addr_q [$];
  logic [7:0]    wr_data_q [$];
  int            wr_cyc_q  [$];
  bit            wr_abort_q[$];
  logic [DW-1:0] exp_rd_q  [$];
  logic [DW-1:0] rd_obs_q  [$];
  logic [DW-1:0] rd_exp_q  [$];
  int            done_cnt, done_cyc, busy_cnt, m16_act, gnt_cnt, rd_unexp;
  logic          done_abt, gnt_seen;
  logic [AW-1:0] done_copied;
  int            start_cyc;

  always @(negedge clk) begin
    if (!rst) begin
      exp_rd_q.delete();
      gnt_seen <= 1'b0;
    end else begin
      if (m8_we) begin
        wr_addr_q.push_back(m8_addr);
        wr_data_q.push_back(m8_wdata);
        wr_cyc_q.push_back(cyc - start_cyc);
        wr_abort_q.push_back(abort);
      end
      if (done) begin
        done_cnt    <= done_cnt + 1;
        done_cyc    <= cyc - start_cyc;
        done_abt    <= aborted;
        done_copied <= copied;
      end
      if (busy) busy_cnt <= busy_cnt + 1;
      if (m16_we || m16_addr != '0 || m16_wdata != '0) m16_act <= m16_act + 1;
      if (host_gnt) gnt_cnt <= gnt_cnt + 1;
      if (host_rvalid) begin
        if (exp_rd_q.size() == 0) rd_unexp <= rd_unexp + 1;
        else begin
          rd_obs_q.push_back(host_rdata);
          rd_exp_q.push_back(exp_rd_q.pop_front());
        end
      end
      if (host_gnt && !host_we) exp_rd_q.push_back(ref16[host_addr]);
      gnt_seen <= host_gnt;
    end
  end

  // Host traffic: 0 idle, 1 back-to-back requests, 2 random requests
  int host_mode;
  initial begin
    host_req = 1'b0; host_we = 1'b0; host_addr = '0; host_wdata = '0;
    forever begin
      @(posedge clk); #1;
      if (!host_req || gnt_seen) begin
        if (host_mode == 1 || (host_mode == 2 && $urandom_range(0, 2) == 0)) begin
          host_req   = 1'b1;
          host_we    = (host_mode == 2) ? 1'($urandom_range(0, 1)) : ($urandom_range(0, 3) == 0);
          host_addr  = 16'(16'h8000 | $urandom_range(0, 255));
          host_wdata = 16'($urandom);
        end else begin
          host_req = 1'b0;
        end
      end
    end
  end

  int n_chk, n_err;
  int d_snap, w_snap, b_snap, m_snap, g_snap, rd_idx;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic launch(input logic [AW-1:0] b, input logic [AW-1:0] n);
    @(posedge clk); #1;
    start = 1'b1; base_addr = b; word_count = n;
    start_cyc = cyc;
    d_snap = done_cnt; w_snap = wr_addr_q.size(); b_snap = busy_cnt;
    m_snap = m16_act;  g_snap = gnt_cnt;
    @(posedge clk); #1;
    start = 1'b0; base_addr = 16'($urandom); word_count = 16'($urandom);
  endtask

  task automatic wait_done(input bit rnd_abort);
    int n = 0;
    while (done_cnt == d_snap && n < 300) begin
      @(posedge clk); #1;
      if (rnd_abort) abort = ($urandom_range(0, 7) == 0);
      n++;
    end
    abort = 1'b0;
    chk("done_pulse", done_cnt - d_snap, 1);
  endtask

  task automatic wait_cyc_to(input int target);
    while (cyc < target) begin @(posedge clk); #1; end
  endtask

  // Reference: words go out in address order until count or a sampled abort
  task automatic check_copy(input string tag, input logic [AW-1:0] b, input int cnt);
    int nwr, k;
    logic [DW-1:0] w;
    nwr = wr_addr_q.size() - w_snap;
    k = cnt;
    for (int i = 0; i < cnt; i++) begin
      if (i < nwr && wr_abort_q[w_snap + i]) begin k = i + 1; break; end
    end
    chk({tag, "_nwr"}, nwr, k);
    for (int i = 0; i < k && i < nwr; i++) begin
      w = ref16[16'(b + 16'(i))];
      chk({tag, "_m8a"}, wr_addr_q[w_snap + i], w[15:8]);
      chk({tag, "_m8d"}, wr_data_q[w_snap + i], w[7:0]);
    end
    chk({tag, "_copied"}, done_copied, k);
    chk({tag, "_aborted"}, done_abt, (k < cnt) ? 1 : 0);
  endtask

  task automatic drain_rd();
    while (rd_idx < rd_obs_q.size()) begin
      chk("host_rdata", rd_obs_q[rd_idx], rd_exp_q[rd_idx]);
      rd_idx++;
    end
  endtask

  task automatic quiesce();
    int n = 0;
    host_mode = 0;
    while (host_req && n < 50) begin @(posedge clk); #1; n++; end
    chk("host_quiet", host_req, 0);
    repeat (RD_LAT + 2) @(posedge clk);
    #1;
    drain_rd();
  endtask

  task automatic poke(input logic [AW-1:0] a, input logic [DW-1:0] d);
    @(posedge clk); #1;
    bd_we = 1'b1; bd_addr = a; bd_data = d;
    @(posedge clk); #1;
    bd_we = 1'b0;
  endtask

  task automatic check_zero(input string t);
    chk({t, "_busy"}, busy, 0);         chk({t, "_done"}, done, 0);
    chk({t, "_aborted"}, aborted, 0);   chk({t, "_copied"}, copied, 0);
    chk({t, "_gnt"}, host_gnt, 0);      chk({t, "_rvalid"}, host_rvalid, 0);
    chk({t, "_rdata"}, host_rdata, 0);  chk({t, "_m16a"}, m16_addr, 0);
    chk({t, "_m16we"}, m16_we, 0);      chk({t, "_m16wd"}, m16_wdata, 0);
    chk({t, "_m8we"}, m8_we, 0);        chk({t, "_m8a"}, m8_addr, 0);
    chk({t, "_m8d"}, m8_wdata, 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog simulation did not finish, observed cycle %0d", cyc);
    $fatal(1);
  end

  initial begin
    logic [7:0] ea [3];
    logic [7:0] ed [3];
    int n;
    ea = '{8'h12, 8'h56, 8'hFF};
    ed = '{8'h34, 8'hAB, 8'h00};
    rst = 1'b0; start = 1'b0; abort = 1'b0; base_addr = '0; word_count = '0;
    preload = 1'b1; bd_we = 1'b0; bd_addr = '0; bd_data = '0; host_mode = 0;
    repeat (3) @(posedge clk);
    #1 preload = 1'b0;
    check_zero("rst_init");
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;

    // fixed three-word copy, uncontested timing
    poke(16'h0010, 16'h1234); poke(16'h0011, 16'h56AB); poke(16'h0012, 16'hFF00);
    launch(16'h0010, 16'd3);
    wait_done(1'b0);
    check_copy("basic", 16'h0010, 3);
    for (int i = 0; i < 3; i++) begin
      chk("basic_addr", wr_addr_q[w_snap + i], ea[i]);
      chk("basic_data", wr_data_q[w_snap + i], ed[i]);
      chk("basic_wcyc", wr_cyc_q[w_snap + i], 3 * (i + 1));
    end
    chk("basic_donecyc", done_cyc, 10);

    // zero-length copy
    launch(16'h1234, 16'd0);
    wait_done(1'b0);
    chk("zero_donecyc", done_cyc, 1);
    chk("zero_aborted", done_abt, 0);
    chk("zero_nwr", wr_addr_q.size() - w_snap, 0);
    chk("zero_m16", m16_act - m_snap, 0);
    chk("zero_busy", busy_cnt - b_snap, 0);

    // address wrap
    launch(16'hFFFF, 16'd2);
    wait_done(1'b0);
    check_copy("wrap", 16'hFFFF, 2);

    // host requesting every cycle during a four-word copy
    host_mode = 1;
    repeat (4) @(posedge clk);
    #1;
    launch(16'h0100, 16'd4);
    wait_done(1'b0);
    check_copy("cont", 16'h0100, 4);
    chk("cont_donecyc", done_cyc, 17);
    chk("cont_hostgnt", gnt_cnt - g_snap, 13);
    quiesce();

    // abort during word 2 of 6, with a start pulse while busy
    launch(16'h0200, 16'd6);
    @(posedge clk); #1;
    start = 1'b1; base_addr = 16'h0300; word_count = 16'd1;
    @(posedge clk); #1;
    start = 1'b0;
    wait_cyc_to(start_cyc + 5);
    abort = 1'b1;
    wait_cyc_to(start_cyc + 7);
    abort = 1'b0;
    wait_done(1'b0);
    check_copy("abort", 16'h0200, 6);
    chk("abort_copied", done_copied, 2);
    chk("abort_flag", done_abt, 1);
    chk("abort_donecyc", done_cyc, 7);
    repeat (5) @(posedge clk);
    #1;
    chk("ignored_start_busy", busy, 0);
    chk("ignored_start_done", done_cnt - d_snap, 1);

    // randomized copies with random host traffic and random abort levels
    for (int it = 0; it < 25; it++) begin
      logic [AW-1:0] b;
      int c;
      b = 16'($urandom_range(0, 16'h7F00));
      c = $urandom_range(1, 8);
      host_mode = 2;
      launch(b, 16'(c));
      wait_done(1'b1);
      check_copy("rand", b, c);
      drain_rd();
    end
    quiesce();

    // reset in the middle of word 2 of 5 with host traffic running
    host_mode = 1;
    launch(16'h0400, 16'd5);
    n = 0;
    while (wr_addr_q.size() == w_snap && n < 100) begin @(posedge clk); #1; n++; end
    chk("rstmid_first_wr", wr_addr_q.size() - w_snap, 1);
    @(posedge clk); #1;
    @(posedge clk); #2;
    rst = 1'b0;
    #1;
    check_zero("rst_mid");
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    b_snap = busy_cnt;
    host_mode = 0;
    repeat (10) @(posedge clk);
    #1;
    chk("rstmid_busy", busy_cnt - b_snap, 0);
    chk("rstmid_nodone", done_cnt - d_snap, 0);
    quiesce();
    chk("rvalid_unexpected", rd_unexp, 0);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule

// File: doc/mem_copy_sched.md
Name: mem_copy_sched

Overview:
- Sequences block transfers out of the 16-bit word memory into the 8-bit memory, and shares the 16-bit memory port between a host requester and the internal copy engine.
- Each source word is split on transfer: bits [15:8] become the 8-bit-memory address, bits [7:0] become the data written.
- Sits between the top-level control/testbench interface and the memory16b / memory8b instances, replacing free-running enable-driven sequencing.

Parameters:
- AW, 16, 16-bit memory address width.
- DW, 16, 16-bit memory data width (must be even; split into two halves of DW/2).
- RD_LAT, 1, 16-bit memory read latency in cycles (synchronous read); supported values are 1 and 2.

Ports:
- clk  in  1  system clock, all logic on rising edge.
- rst  in  1  asynchronous, active-low reset.
- start  in  1  one-cycle pulse that launches a copy; sampled only in IDLE.
- abort  in  1  level; when high, the copy stops at the next word boundary.
- base_addr  in  AW  first source word address.
- word_count  in  AW  number of words to copy.
- busy  out  1  high from the cycle after an accepted start until DONE.
- done  out  1  one-cycle pulse when a copy finishes or is aborted.
- aborted  out  1  valid with done; high if the copy ended by abort.
- copied  out  AW  count of words written to the 8-bit memory in the current or last copy.
- host_req  in  1  host access request, level, held until granted.
- host_we  in  1  1 = host write, 0 = host read.
- host_addr  in  AW  host address.
- host_wdata  in  DW  host write data.
- host_gnt  out  1  one-cycle grant; the host access is issued in this cycle.
- host_rvalid  out  1  pulse RD_LAT cycles after a granted host read.
- host_rdata  out  DW  valid with host_rvalid.
- m16_addr  out  AW  16-bit memory address.
- m16_we  out  1  16-bit memory write strobe.
- m16_wdata  out  DW  16-bit memory write data.
- m16_rdata  in  DW  16-bit memory read data, RD_LAT cycles after the address.
- m8_addr  out  DW/2  8-bit memory address.
- m8_wdata  out  DW/2  8-bit memory write data.
- m8_we  out  1  8-bit memory write strobe.

Behaviour:
- Reset (rst=0, asynchronous):
  - state=IDLE.
  - All outputs are 0: busy, done, aborted, copied, host_gnt, host_rvalid, m16_we, m8_we, all address and data buses.
  - Round-robin pointer = host.
  - Reset mid-copy drops the copy with no done pulse. An in-flight read is discarded and produces no host_rvalid.
- States:
  - IDLE: start with word_count != 0 latches base_addr into cur_addr and word_count into remaining, clears copied, and moves to RUN.
  - IDLE: start with word_count=0 moves to DONE directly; no memory access occurs.
  - RUN: arbitrate for the 16-bit memory slot.
  - WAIT: count RD_LAT cycles for the copy read.
  - WRITE: 8-bit memory write.
  - DONE: done=1 for one cycle, busy=0, then return to IDLE.
- Arbitration (one 16-bit access per cycle):
  - In IDLE, and in WAIT/WRITE, the host is granted whenever host_req=1.
  - In RUN, if host_req=1 the grant goes to whichever of host/copy was not granted last in RUN (round-robin). The pointer flips after each contested grant.
  - host_gnt is combinational from host_req and state. The m16 outputs carry the host request in the grant cycle.
- Copy read:
  - On a copy grant in RUN, drive m16_addr=cur_addr, m16_we=0, then go to WAIT.
  - The return word is captured after RD_LAT cycles, then go to WRITE.
  - Host reads granted during WAIT must not collide with the copy capture; the read-tag pipeline routes each return to host_rdata or to the copy register.
- WRITE (exactly one cycle):
  - m8_we=1, m8_addr=word[DW-1:DW/2], m8_wdata=word[DW/2-1:0].
  - copied+=1, remaining-=1, cur_addr+=1 modulo 2^AW (0xFFFF wraps to 0x0000).
  - Next state: DONE if remaining reaches 0 or abort=1; otherwise RUN.
- Abort: sampled only at the WRITE cycle, so the word in progress always completes. aborted=1 with done if abort was the exit cause; an abort that coincides with the last word reports aborted=0.
- start while busy: ignored, with no side effects.
- Latency:
  - Uncontested copy = 1 + RD_LAT + 1 cycles per word; RD_LAT=1 gives 3 cycles/word.
  - done appears 1 cycle after the last m8_we.

Decomposition:
- Package mem_ctrl_pkg:
  - state enum {IDLE, RUN, WAIT, WRITE, DONE}.
  - AW and DW defaults.
  - Owner enum {OWN_HOST, OWN_COPY} for the read-tag pipeline.
- One sub-module, rd_tag_pipe: an RD_LAT-deep shift register of {valid, owner}. It steers m16_rdata to host_rdata/host_rvalid or to the copy capture register.

Test Plan:
- Reset check: rst=0 mid-copy at word 2 of 5 -> all outputs 0 immediately, no done pulse; after release, busy stays 0.
- Basic copy: mem16[0x0010..0x0012]={0x1234,0x56AB,0xFF00}, start with base=0x0010, count=3, no host traffic -> m8 writes (0x12,0x34),(0x56,0xAB),(0xFF,0x00) at cycles 3,6,9 after start; done at cycle 10; copied=3.
- Zero count: start with count=0 -> done pulse 1 cycle later, aborted=0, no m16 or m8 strobes.
- Wrap: base=0xFFFF, count=2 -> reads 0xFFFF then 0x0000; copied=2.
- Contention: host_req held high during a 4-word copy -> host and copy grants alternate in RUN, every host read returns correct host_rdata, and the copy result matches the uncontested case.
- Abort: abort asserted during WAIT of word 2 of 6 -> word 2 is still written, done with aborted=1, copied=2; start while busy is ignored.
